// File: rtl/tnn_stream_pkg.sv
// Shared widths and FSM encoding for the TNN result-stream packer.
// Imported by the packer top and by its testbench.
package tnn_stream_pkg;

  localparam int IN_W  = 64;
  localparam int OUT_W = 512;
  localparam int LANES = OUT_W / IN_W;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD
  } packer_state_t;

endpackage

// File: rtl/tnn_out_slice.sv
// Single-entry valid/ready register slice.
// Data only changes when the slot is empty or draining, so the output is stable under back-pressure.
module tnn_out_slice #(
  parameter int W = 513
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [W-1:0] push_data,
  input  logic         push_vld,
  output logic         push_rdy,
  output logic [W-1:0] pop_data,
  output logic         pop_vld,
  input  logic         pop_rdy
);

  logic [W-1:0] data_reg;
  logic         vld_reg;

  assign push_rdy = !vld_reg | pop_rdy;
  assign pop_data = data_reg;
  assign pop_vld  = vld_reg;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data_reg <= '0;
      vld_reg  <= 1'b0;
    end else if (push_vld & push_rdy) begin
      data_reg <= push_data;
      vld_reg  <= 1'b1;
    end else if (pop_rdy) begin
      vld_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/tnn_stream_packer.sv
// Packs 64-bit result words into 512-bit beats with frame closing on a programmed word count.
// The accumulator doubles as a second buffer (HOLD) while the output slice is stalled.
module tnn_stream_packer
  import tnn_stream_pkg::*;
#(
  parameter int IN_W  = tnn_stream_pkg::IN_W,
  parameter int OUT_W = tnn_stream_pkg::OUT_W,
  parameter int CNT_W = tnn_stream_pkg::CNT_W
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [CNT_W-1:0] frame_len,
  input  logic [IN_W-1:0]  s_bits,
  input  logic             s_vld,
  output logic             s_rdy,
  output logic [OUT_W-1:0] m_bits,
  output logic             m_vld,
  input  logic             m_rdy,
  output logic             m_last,
  output logic [31:0]      frames_done,
  output logic             busy
);

  localparam int NLANES = OUT_W / IN_W;
  localparam int LANE_W = (NLANES > 1) ? $clog2(NLANES) : 1;

  packer_state_t    state_reg, state_next;
  logic [LANE_W-1:0] lane_reg, lane_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] len_reg, len_next;
  logic [OUT_W-1:0] acc_reg, acc_next;
  logic             hold_last_reg, hold_last_next;
  logic [31:0]      frames_done_reg;

  logic             in_hs;
  logic             slot_free;
  logic             push_vld;
  logic             push_last;
  logic [OUT_W-1:0] push_bits;
  logic [OUT_W-1:0] merged;
  logic [CNT_W-1:0] cur_len;
  logic [CNT_W-1:0] cnt_inc;
  logic             frame_end;
  logic             beat_done;

  // Lanes above the current one are still zero in the accumulator, which gives the zero padding.
  generate
    for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
      assign merged[gi*IN_W +: IN_W] = (lane_reg == LANE_W'(gi)) ? s_bits
                                                                 : acc_reg[gi*IN_W +: IN_W];
    end
  endgenerate

  assign s_rdy     = (state_reg != HOLD);
  assign in_hs     = s_vld & s_rdy;
  assign cur_len   = (state_reg == IDLE) ? ((frame_len == '0) ? CNT_W'(1) : frame_len) : len_reg;
  assign cnt_inc   = (state_reg == IDLE) ? CNT_W'(1) : cnt_reg + CNT_W'(1);
  assign frame_end = (cnt_inc == cur_len);
  assign beat_done = (lane_reg == LANE_W'(NLANES - 1)) | frame_end;

  always_comb begin
    state_next     = state_reg;
    lane_next      = lane_reg;
    cnt_next       = cnt_reg;
    len_next       = len_reg;
    acc_next       = acc_reg;
    hold_last_next = hold_last_reg;
    push_vld       = 1'b0;
    push_bits      = acc_reg;
    push_last      = hold_last_reg;
    case (state_reg)
      HOLD: begin
        if (slot_free) begin
          push_vld   = 1'b1;
          acc_next   = '0;
          state_next = hold_last_reg ? IDLE : FILL;
        end
      end
      default: begin
        if (in_hs) begin
          if (state_reg == IDLE) len_next = cur_len;
          cnt_next = frame_end ? '0 : cnt_inc;
          if (beat_done) begin
            lane_next = '0;
            if (slot_free) begin
              push_vld   = 1'b1;
              push_bits  = merged;
              push_last  = frame_end;
              acc_next   = '0;
              state_next = frame_end ? IDLE : FILL;
            end else begin
              acc_next       = merged;
              hold_last_next = frame_end;
              state_next     = HOLD;
            end
          end else begin
            lane_next  = lane_reg + LANE_W'(1);
            acc_next   = merged;
            state_next = FILL;
          end
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg     <= IDLE;
      lane_reg      <= '0;
      cnt_reg       <= '0;
      len_reg       <= '0;
      acc_reg       <= '0;
      hold_last_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lane_reg      <= lane_next;
      cnt_reg       <= cnt_next;
      len_reg       <= len_next;
      acc_reg       <= acc_next;
      hold_last_reg <= hold_last_next;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frames_done_reg <= '0;
    end else if (m_vld & m_rdy & m_last) begin
      frames_done_reg <= frames_done_reg + 32'd1;
    end
  end

  tnn_out_slice #(
    .W(OUT_W + 1)
  ) u_out_slice (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .push_data({push_last, push_bits}),
    .push_vld (push_vld),
    .push_rdy (slot_free),
    .pop_data ({m_last, m_bits}),
    .pop_vld  (m_vld),
    .pop_rdy  (m_rdy)
  );

  assign frames_done = frames_done_reg;
  assign busy        = (state_reg != IDLE) | m_vld;

endmodule

// File: doc/tnn_stream_packer.md
# tnn_stream_packer

Packs the 64-bit per-cycle result stream of the TNN accelerator into 512-bit beats for the output FIFO. Unlike a free-running upsizer, it honours back-pressure on both sides, closes each image frame on a programmable word count, and zero-pads the final partial beat. It sits between the accelerator's result port and the 512-bit output FIFO write side, in the accelerator clock domain.

## Interface
- `IN_W`, default 64: input word width.
- `OUT_W`, default 512: output beat width; `LANES = OUT_W/IN_W = 8`.
- `CNT_W`, default 16: width of the frame-length field.

Ports:
- `aclk`  in  1: clock; all logic is on the rising edge.
- `aresetn`  in  1: asynchronous reset, active low.
- `frame_len`  in  CNT_W: input words per frame.
- `s_bits`  in  IN_W: input word.
- `s_vld`  in  1: input valid.
- `s_rdy`  out  1: input ready.
- `m_bits`  out  OUT_W: packed beat.
- `m_vld`  out  1: output valid.
- `m_rdy`  in  1: output ready; tie to `!full` of the FIFO.
- `m_last`  out  1: beat is the final beat of its frame.
- `frames_done`  out  32: count of completed frames.
- `busy`  out  1: a frame is in progress or a beat is pending.

## Operation
- An input handshake is `s_vld & s_rdy`. An output handshake is `m_vld & m_rdy`.
- State machine with three states:
  - `IDLE`: no frame open.
  - `FILL`: accumulating input words.
  - `HOLD`: the accumulator is complete but the output register is occupied.
- **Starting a frame:** the first input handshake in `IDLE` samples `frame_len` into `len_q` and moves to `FILL`.
  - `frame_len == 0` is treated as 1.
  - `frame_len` is ignored at all other times.
- **Lane placement:** input word k of a beat is written to bits `[IN_W*k +: IN_W]`, with lane 0 at the LSBs. The lane counter is 0..7.
- **Word counting:** the frame word counter runs from 1 to `len_q`. A beat completes when lane 7 is written or the counter reaches `len_q`.
  - Unwritten lanes of a beat are zero.
  - A beat that completes on `len_q` carries `last = 1`.
- **Completed beat:**
  - If the output register is empty, or is handshaking in the same cycle, the beat moves into it and the lane counter resets to 0.
  - Otherwise the FSM enters `HOLD`.
  - The FSM then goes to `IDLE` if `last` was set, else to `FILL`.
- `s_rdy = (state != HOLD)`. The output register is a single-entry slice holding `m_bits`, `m_last` and `m_vld`.
- `HOLD` is left on the output handshake: the held beat moves into the output register in that same cycle.
- `frames_done` increments on each output handshake with `m_last = 1`, and wraps modulo 2^32.
- `busy = (state != IDLE) | m_vld`.

## Timing
- **Reset values:** `s_rdy = 1` (as soon as `aresetn` is high), `m_vld = 0`, `m_last = 0`, `m_bits = 0`, `frames_done = 0`, `busy = 0`, state `IDLE`, counters 0.
- **Latency:** a beat-completing input handshake in cycle N gives `m_vld = 1` in cycle N+1.
- **Throughput:** one input word per cycle, sustained, while `m_rdy = 1`. There is no bubble at beat or frame boundaries, and a new frame may begin in the cycle after the last word of the previous frame.
- **Back-pressure:**
  - With `m_rdy = 0` held, at most 2 beats are buffered (output register plus accumulator), after which `s_rdy` drops.
  - `s_rdy` rises in the cycle after the output handshake.
- **Output stability:** `m_bits` and `m_last` are stable while `m_vld & !m_rdy`.
- **Reset mid-frame:** partial data is discarded, and the next word after reset lands in lane 0 of a new frame.

## Structure
- Shared package `tnn_stream_pkg` holds:
  - `IN_W`, `OUT_W`, `LANES`
  - the `packer_state_t` enum (`IDLE`, `FILL`, `HOLD`)
- One sub-module, `tnn_out_slice`: a single-entry valid/ready register slice carrying `{last, bits}`.
- The FSM, lane counter, frame counter and accumulator live in the top module.

## Test plan
- **Full beat:** `frame_len = 8`, words 0x1..0x8 back-to-back, `m_rdy = 1` → one beat with lane k = k+1, `m_last = 1`, `frames_done = 1`, `m_vld` high one cycle after the 8th word.
- **Partial beat:** `frame_len = 3`, words 0xA, 0xB, 0xC → lanes 0–2 = A, B, C; lanes 3–7 = 0; `m_last = 1`.
- **Two-beat frame:** `frame_len = 10` → beat 1 is full with `m_last = 0`; beat 2 holds words 9–10 in lanes 0–1, the rest zero, `m_last = 1`.
- **Back-pressure:** `frame_len = 24`, `m_rdy = 0` for 30 cycles with `s_vld` held high → `s_rdy` falls after exactly 16 accepted words. Then raise `m_rdy` → 3 beats emerge in order, none lost.
- **Reset mid-frame:** reset after 5 words → `m_vld = 0` and `frames_done = 0`. A new 8-word frame then packs from lane 0.
- **Edge lengths:** `frame_len = 0` → each word is its own frame (lane 0, `m_last = 1`). Preloading `frames_done` to 0xFFFFFFFF via force, then one frame → wraps to 0.
